// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: synchronised switch inputs, SPEED-scaled step prescaler and
// four step patterns (blink, running light, bounce, bar fill) on a registered 10-LED output.
module led_pattern_seq #(
  parameter int unsigned TICK_DIV = 6_250_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [1:0] MODE,
  input  logic [1:0] SPEED,
  input  logic       PAUSE,
  output logic [9:0] LEDR,
  output logic       TICK
);

  typedef enum logic [1:0] {
    ModeBlink  = 2'b00,
    ModeRun    = 2'b01,
    ModeBounce = 2'b10,
    ModeBar    = 2'b11
  } mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  logic [1:0] r_mode_s1, r_mode_s2;
  logic [1:0] r_speed_s1, r_speed_s2;
  logic       r_pause_s1, r_pause_s2;

  mode_e       r_mode_q;
  logic [31:0] r_cnt;
  logic [3:0]  r_pos;
  dir_e        r_dir;
  logic [9:0]  r_led;
  logic        r_tick;

  mode_e       w_mode_sync;
  logic [31:0] w_limit;
  logic        w_step;
  logic        w_restart;
  logic [3:0]  w_pos_nxt;
  dir_e        w_dir_nxt;
  logic [9:0]  w_led_nxt;
  logic [10:0] w_bar;
  logic [9:0]  w_led_init;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_mode_s1  <= 2'b00;
      r_mode_s2  <= 2'b00;
      r_speed_s1 <= 2'b00;
      r_speed_s2 <= 2'b00;
      r_pause_s1 <= 1'b0;
      r_pause_s2 <= 1'b0;
    end else begin
      r_mode_s1  <= MODE;
      r_mode_s2  <= r_mode_s1;
      r_speed_s1 <= SPEED;
      r_speed_s2 <= r_speed_s1;
      r_pause_s1 <= PAUSE;
      r_pause_s2 <= r_pause_s1;
    end
  end

  // Compare with >= so a SPEED decrease below the running count steps immediately.
  always_comb begin
    w_mode_sync = mode_e'(r_mode_s2);
    w_limit     = 32'(TICK_DIV) << r_speed_s2;
    w_step      = (r_cnt >= (w_limit - 32'd1));
    w_restart   = (w_mode_sync != r_mode_q);
  end

  always_comb begin
    w_pos_nxt = r_pos;
    w_dir_nxt = r_dir;
    w_led_nxt = r_led;
    w_bar     = 11'd0;
    unique case (r_mode_q)
      ModeBlink: begin
        w_led_nxt = ~r_led;
      end
      ModeRun: begin
        w_pos_nxt = (r_pos >= 4'd9) ? 4'd0 : r_pos + 4'd1;
        w_led_nxt = 10'd1 << w_pos_nxt;
      end
      ModeBounce: begin
        // End positions turn around immediately so neither end is shown twice in a row.
        if (r_pos > 4'd9) begin
          w_pos_nxt = 4'd0;
          w_dir_nxt = DirUp;
        end else if (r_dir == DirUp) begin
          if (r_pos == 4'd9) begin
            w_pos_nxt = 4'd8;
            w_dir_nxt = DirDown;
          end else begin
            w_pos_nxt = r_pos + 4'd1;
          end
        end else begin
          if (r_pos == 4'd0) begin
            w_pos_nxt = 4'd1;
            w_dir_nxt = DirUp;
          end else begin
            w_pos_nxt = r_pos - 4'd1;
          end
        end
        w_led_nxt = 10'd1 << w_pos_nxt;
      end
      ModeBar: begin
        w_pos_nxt = (r_pos >= 4'd10) ? 4'd0 : r_pos + 4'd1;
        w_bar     = (11'd1 << w_pos_nxt) - 11'd1;
        w_led_nxt = w_bar[9:0];
      end
      default: begin
        w_pos_nxt = 4'd0;
      end
    endcase
  end

  always_comb begin
    w_led_init = 10'h000;
    if (w_mode_sync == ModeRun || w_mode_sync == ModeBounce) begin
      w_led_init = 10'h001;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_mode_q <= ModeBlink;
      r_cnt    <= 32'd0;
      r_pos    <= 4'd0;
      r_dir    <= DirUp;
      r_led    <= 10'h000;
      r_tick   <= 1'b0;
    end else if (w_restart) begin
      r_mode_q <= w_mode_sync;
      r_cnt    <= 32'd0;
      r_pos    <= 4'd0;
      r_dir    <= DirUp;
      r_led    <= w_led_init;
      r_tick   <= 1'b0;
    end else if (r_pause_s2) begin
      r_tick <= 1'b0;
    end else if (w_step) begin
      r_cnt  <= 32'd0;
      r_pos  <= w_pos_nxt;
      r_dir  <= w_dir_nxt;
      r_led  <= w_led_nxt;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 32'd1;
      r_tick <= 1'b0;
    end
  end

  assign LEDR = r_led;
  assign TICK = r_tick;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq: vector table for the pattern sequences plus
// hand-written sequences for SPEED changes, PAUSE, mid-period restart and async reset.
module tb_led_pattern_seq;

  logic       clk = 1'b0;
  logic       RESET;
  logic [1:0] MODE;
  logic [1:0] SPEED;
  logic       PAUSE;
  logic [9:0] LEDR;
  logic       TICK;

  int n_checks = 0;
  int n_errors = 0;

  led_pattern_seq #(
    .TICK_DIV(4)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (RESET),
    .MODE    (MODE),
    .SPEED   (SPEED),
    .PAUSE   (PAUSE),
    .LEDR    (LEDR),
    .TICK    (TICK)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [1:0] speed;
    logic       pause;
    int         adv;
    logic [9:0] ledr;
    logic       tick;
  } vec_t;

  vec_t vecs[$];

  localparam logic [9:0] RunExp [9] = '{10'h004, 10'h008, 10'h010, 10'h020, 10'h040,
                                        10'h080, 10'h100, 10'h200, 10'h001};
  localparam logic [9:0] BounceExp [19] = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020,
                                            10'h040, 10'h080, 10'h100, 10'h200, 10'h100,
                                            10'h080, 10'h040, 10'h020, 10'h010, 10'h008,
                                            10'h004, 10'h002, 10'h001, 10'h002};
  localparam logic [9:0] BarExp [11] = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F, 10'h03F,
                                         10'h07F, 10'h0FF, 10'h1FF, 10'h3FF, 10'h000};
  localparam logic [9:0] BlinkExp [4] = '{10'h3FF, 10'h000, 10'h3FF, 10'h000};

  function automatic vec_t mk(input logic [1:0] m, input logic [1:0] s, input logic p,
                              input int adv, input logic [9:0] l, input logic t);
    vec_t v;
    v.mode  = m;
    v.speed = s;
    v.pause = p;
    v.adv   = adv;
    v.ledr  = l;
    v.tick  = t;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns the number of edges until TICK is seen high, or -1 on timeout.
  task automatic wait_tick(input int max_edges, output int n);
    n = -1;
    for (int i = 1; i <= max_edges && n < 0; i++) begin
      @(posedge clk);
      #1;
      if (TICK === 1'b1) n = i;
    end
  endtask

  initial begin
    int n;
    int bad;

    RESET = 1'b1;
    MODE  = 2'b01;
    SPEED = 2'b00;
    PAUSE = 1'b0;

    // RUN from reset release: restart on edge 3, steps every 4 edges from edge 7.
    vecs.push_back(mk(2'b01, 2'b00, 1'b0, 1, 10'h000, 1'b0));
    vecs.push_back(mk(2'b01, 2'b00, 1'b0, 1, 10'h000, 1'b0));
    vecs.push_back(mk(2'b01, 2'b00, 1'b0, 1, 10'h001, 1'b0));
    vecs.push_back(mk(2'b01, 2'b00, 1'b0, 3, 10'h001, 1'b0));
    vecs.push_back(mk(2'b01, 2'b00, 1'b0, 1, 10'h002, 1'b1));
    vecs.push_back(mk(2'b01, 2'b00, 1'b0, 1, 10'h002, 1'b0));
    for (int k = 0; k < 9; k++) vecs.push_back(mk(2'b01, 2'b00, 1'b0, (k == 0) ? 3 : 4,
                                                  RunExp[k], 1'b1));
    vecs.push_back(mk(2'b10, 2'b00, 1'b0, 3, 10'h001, 1'b0));
    for (int k = 0; k < 19; k++) vecs.push_back(mk(2'b10, 2'b00, 1'b0, 4, BounceExp[k], 1'b1));
    vecs.push_back(mk(2'b11, 2'b00, 1'b0, 3, 10'h000, 1'b0));
    for (int k = 0; k < 11; k++) vecs.push_back(mk(2'b11, 2'b00, 1'b0, 4, BarExp[k], 1'b1));
    vecs.push_back(mk(2'b00, 2'b00, 1'b0, 3, 10'h000, 1'b0));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(2'b00, 2'b00, 1'b0, 4, BlinkExp[k], 1'b1));

    repeat (2) @(posedge clk);
    #1;
    check("reset_ledr", int'(LEDR), 'h000);
    check("reset_tick", int'(TICK), 0);
    RESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      MODE  = vecs[i].mode;
      SPEED = vecs[i].speed;
      PAUSE = vecs[i].pause;
      repeat (vecs[i].adv) @(posedge clk);
      #1;
      n_checks++;
      if ({LEDR, TICK} !== {vecs[i].ledr, vecs[i].tick}) begin
        n_errors++;
        $display("FAIL vec%0d: LEDR=%03h TICK=%0b, expected LEDR=%03h TICK=%0b",
                 i, LEDR, TICK, vecs[i].ledr, vecs[i].tick);
      end
    end

    // SPEED=2: period 16 in BLINK.
    SPEED = 2'b10;
    wait_tick(40, n);
    check("speed2_first", n, 16);
    check("speed2_led", int'(LEDR), 'h3FF);
    wait_tick(40, n);
    check("speed2_period", n, 16);

    // SPEED=3 until cnt=20, then SPEED=0 steps right after the synchroniser.
    SPEED = 2'b11;
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (TICK !== 1'b0) bad++;
    end
    check("speed3_no_tick", bad, 0);
    SPEED = 2'b00;
    wait_tick(10, n);
    check("speed_drop_tick", n, 3);
    check("speed_drop_led", int'(LEDR), 'h3FF);
    wait_tick(10, n);
    check("speed0_period", n, 4);
    check("speed0_led", int'(LEDR), 'h000);

    // PAUSE mid-period in RUN.
    MODE = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    check("pause_restart_led", int'(LEDR), 'h001);
    PAUSE = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (LEDR !== 10'h001 || TICK !== 1'b0) bad++;
    end
    check("pause_frozen", bad, 0);
    PAUSE = 1'b0;
    wait_tick(20, n);
    check("pause_resume_tick", n, 4);
    check("pause_resume_led", int'(LEDR), 'h002);
    wait_tick(10, n);
    check("pause_next_tick", n, 4);
    check("pause_next_led", int'(LEDR), 'h004);
    repeat (3) wait_tick(10, n);
    check("run_to_020", int'(LEDR), 'h020);

    // MODE change mid-period; restart coincides with a due step and must win.
    repeat (1) @(posedge clk);
    #1;
    MODE = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("bar_restart", int'({LEDR, TICK}), int'({10'h000, 1'b0}));
    repeat (3) @(posedge clk);
    #1;
    check("bar_hold", int'({LEDR, TICK}), int'({10'h000, 1'b0}));
    @(posedge clk);
    #1;
    check("bar_first_step", int'({LEDR, TICK}), int'({10'h001, 1'b1}));

    // Asynchronous reset between edges, right while TICK is high.
    #2;
    RESET = 1'b1;
    #1;
    check("async_rst_ledr", int'(LEDR), 'h000);
    check("async_rst_tick", int'(TICK), 0);
    MODE = 2'b00;
    @(posedge clk);
    #1;
    RESET = 1'b0;
    wait_tick(20, n);
    check("first_tick_latency", n, 4);
    check("first_tick_led", int'(LEDR), 'h3FF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_seq.md
# led_pattern_seq

Registered LED pattern sequencer for the 10-LED board output. It sits between the 50 MHz clock and `LEDR`, replacing the raw free-running counter bits with a prescaled step tick. That tick drives one of four switch-selected patterns: blink, running light, bounce and bar fill. Step rate, pause and mode are controlled by board switches, and a one-cycle `TICK` strobe is exported for downstream consumers such as a 7-segment step counter.

## Interface
- `TICK_DIV`, default 6_250_000: base step period in `CLOCK_50` cycles (8 Hz at 50 MHz). Legal range is 2 up to 2^29; the bench uses 4.
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `RESET`  in  1  reset. One clock domain; `RESET` is asynchronous and active-high.
- `MODE`  in  2  pattern select (switch): 00 BLINK, 01 RUN, 10 BOUNCE, 11 BAR. Asynchronous input.
- `SPEED`  in  2  period multiplier: step period = `TICK_DIV` << `SPEED`. Asynchronous input.
- `PAUSE`  in  1  freeze prescaler and pattern while high. Asynchronous input.
- `LEDR`  out  10  registered LED pattern.
- `TICK`  out  1  registered one-cycle strobe, high in the cycle `LEDR` shows a new step.

## Operation
- **Input synchronisation:** `MODE`, `SPEED` and `PAUSE` each pass through a 2-flop synchroniser; all synchroniser flops reset to 0. `mode_q` holds the last synchronised `MODE` and resets to 00.
- **Prescaler:**
  - 32-bit `cnt`; `limit` = `TICK_DIV` << `SPEED_sync`, computed in 32 bits.
  - Each cycle, with no restart and no pause: if `cnt` >= `limit`-1 then `cnt` <= 0 and a step fires; else `cnt` <= `cnt`+1.
  - The >= compare is mandatory. When `SPEED` drops below the current count, the step fires on the next edge and the counter never runs past the limit.
- **Restart:** when `MODE_sync` != `mode_q`:
  - `mode_q` <= `MODE_sync`, `cnt` <= 0, `pos` <= 0, `dir` <= up, `TICK` <= 0.
  - `LEDR` <= initial pattern: BLINK 0x000, RUN 0x001, BOUNCE 0x001, BAR 0x000.
- **Priority:** restart > `PAUSE` > step. While `PAUSE_sync` is high, `cnt`, `pos`, `dir` and `LEDR` hold and `TICK` is 0.
- **Step transitions** (`pos` is 4-bit):
  - BLINK: `LEDR` <= ~`LEDR`, giving 0x000 ↔ 0x3FF.
  - RUN: `pos` 0..9 then wraps to 0; `LEDR` = 1 << `pos`.
  - BOUNCE: `pos` goes up to 9, `dir` flips, goes down to 0, `dir` flips. End positions appear exactly once per pass: sequence 0,1,…,9,8,…,1,0,1. `LEDR` = 1 << `pos`.
  - BAR: `pos` 0..10 then wraps to 0 (11 states); `LEDR` = (1 << `pos`) - 1, computed in 11 bits and truncated to 10.
- **Invariant:** `pos` never leaves its mode's legal range. An out-of-range value forces `pos` to 0 on the next step.

## Timing
- **Reset values:** `LEDR` = 0x000, `TICK` = 0, `cnt` = 0, `pos` = 0, `dir` = up, `mode_q` = 00, all synchroniser flops = 0. Assertion of `RESET` clears these immediately, without waiting for a clock edge.
- **Step latency:** with `cnt` = 0 after reset, `TICK` first goes high after edge number `limit`, then once every `limit` cycles, and stays high for exactly 1 cycle. `LEDR` updates on the same edge that raises `TICK`.
- **Input latency:** a `MODE` pin change causes the restart on the 3rd rising edge (2 synchroniser edges plus the compare edge). `PAUSE` and `SPEED` take effect 2 edges after the pin changes.
- **Mode pin at reset release:** if `MODE` ≠ 00 when `RESET` is released, the restart occurs on edge 3. Example: RUN shows 0x001 from edge 3.
- **Restart and step in the same cycle:** the restart wins and `TICK` stays low.
- **Pause release:** counting resumes from the held `cnt`; no step is lost or duplicated.

## Test plan
1. **RUN sequence:** `TICK_DIV`=4, `SPEED`=0, `MODE`=01, release reset → `LEDR`=0x000 for edges 1-2, 0x001 from edge 3. Then `TICK` every 4 cycles, `LEDR` 0x002, 0x004, …, 0x200, then wraps to 0x001.
2. **BOUNCE:** `MODE`=10 → `LEDR` 0x001, 0x002, …, 0x200, 0x100, …, 0x001, 0x002. Neither 0x200 nor 0x001 repeats on consecutive steps.
3. **BAR and BLINK:** BAR (`MODE`=11) → 0x000, 0x001, 0x003, …, 0x1FF, 0x3FF, 0x000 (11 steps). BLINK (`MODE`=00) → 0x000/0x3FF alternating on each `TICK`.
4. **SPEED:** `SPEED`=2 → `TICK` period 16 cycles. With `SPEED`=3, at `cnt`=20 switch to `SPEED`=0 → `TICK` fires on the first edge after `SPEED_sync` updates, then every 4 cycles.
5. **PAUSE:** assert `PAUSE` for 10 cycles mid-period → `LEDR` frozen and `TICK` stays 0. After `PAUSE_sync` falls, the next `TICK` arrives after the remaining count only, and the following step is the next in sequence.
6. **Async reset:** assert `RESET` mid-pattern between clock edges → `LEDR`=0x000 and `TICK`=0 immediately. Change `MODE` mid-period (RUN at 0x020 → BAR) → `LEDR`=0x000 and `cnt`=0 on the 3rd edge, then 0x001 after 4 more cycles.
